// File: rtl/key_conditioner_pkg.sv
// Shared constants and types for the key conditioning front end.
package key_conditioner_pkg;

  // Board key widths.
  localparam int NOTE_KEY_BITS   = 7;
  localparam int LENGTH_KEY_BITS = 7;
  localparam int BTN_BITS        = 4;

  // Button bit positions within btn_raw / btn_level / btn_press.
  localparam int BTN_SUBMIT   = 0;
  localparam int BTN_CANCEL   = 1;
  localparam int BTN_OCT_UP   = 2;
  localparam int BTN_OCT_DOWN = 3;

  // Width of the binary note index.
  localparam int NOTE_IDX_W = 3;

  // Registered result of the note-key one-hot decode.
  typedef struct packed {
    logic                  valid;
    logic [NOTE_IDX_W-1:0] idx;
  } note_dec_t;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_bits(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_conditioner_debounce_bit.sv
// One input bit: 2-flop synchroniser followed by a tick-counted debouncer.
module debounce_bit
  import key_conditioner_pkg::*;
#(
  parameter int DB_MS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level
);

  localparam int CW = cnt_bits(DB_MS);

  logic          sync1, sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  // Bring the asynchronous board input into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Count ticks while the input disagrees with the stable value; any
  // agreement restarts qualification, so bounces never get through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (tick) begin
      if (cnt == CW'(DB_MS - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = stable;

endmodule

// File: rtl/key_conditioner.sv
// Conditions raw board keys/buttons into clean levels, press pulses and
// a pre-decoded note index for the piano controller.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int DB_MS    = 20,
  parameter int NK       = NOTE_KEY_BITS,
  parameter int LK       = LENGTH_KEY_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NK-1:0]         note_key_raw,
  input  logic [LK-1:0]         length_key_raw,
  input  logic [BTN_BITS-1:0]   btn_raw,
  output logic [NK-1:0]         note_key,
  output logic [LK-1:0]         length_key,
  output logic [BTN_BITS-1:0]   btn_level,
  output logic [BTN_BITS-1:0]   btn_press,
  output logic                  note_valid,
  output logic [NOTE_IDX_W-1:0] note_idx,
  output logic                  any_key
);

  localparam int NB    = NK + LK + BTN_BITS;
  localparam int DIV_W = cnt_bits(TICK_DIV - 1);

  logic [DIV_W-1:0]    div_cnt;
  logic                tick;
  logic [NB-1:0]       raw_all;
  logic [NB-1:0]       lvl_all;
  logic [BTN_BITS-1:0] btn_prev;
  note_dec_t           dec_d;

  // Free-running divider shared by every debouncer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      div_cnt <= '0;
    else if (div_cnt == DIV_W'(TICK_DIV - 1))
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

  assign raw_all = {btn_raw, length_key_raw, note_key_raw};

  // One independent debouncer per input bit.
  for (genvar g = 0; g < NB; g++) begin : g_db
    debounce_bit #(.DB_MS(DB_MS)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .raw   (raw_all[g]),
      .level (lvl_all[g])
    );
  end

  assign note_key   = lvl_all[NK-1:0];
  assign length_key = lvl_all[NK +: LK];
  assign btn_level  = lvl_all[NK+LK +: BTN_BITS];

  // Rising-edge detect on debounced buttons; one pulse per press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev  <= '0;
      btn_press <= '0;
    end else begin
      btn_prev  <= btn_level;
      btn_press <= btn_level & ~btn_prev;
    end
  end

  // One-hot decode of the note keys; zero or several set bits is invalid.
  always_comb begin
    logic seen, multi;
    logic [NOTE_IDX_W-1:0] idx;
    seen  = 1'b0;
    multi = 1'b0;
    idx   = '0;
    for (int i = 0; i < NK; i++) begin
      if (note_key[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
        idx  = NOTE_IDX_W'(i);
      end
    end
    dec_d.valid = seen & ~multi;
    dec_d.idx   = dec_d.valid ? idx : '0;
  end

  // Register decode and activity flag so downstream sees clean flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_valid <= 1'b0;
      note_idx   <= '0;
      any_key    <= 1'b0;
    end else begin
      note_valid <= dec_d.valid;
      note_idx   <= dec_d.idx;
      any_key    <= |lvl_all;
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with a press-pulse scoreboard.
module tb_key_conditioner;

  localparam int TICK_DIV = 4;
  localparam int DB_MS    = 3;
  localparam int NK = 7, LK = 7, BB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] note_key_raw = '0;
  logic [LK-1:0] length_key_raw = '0;
  logic [BB-1:0] btn_raw = '0;
  logic [NK-1:0] note_key;
  logic [LK-1:0] length_key;
  logic [BB-1:0] btn_level;
  logic [BB-1:0] btn_press;
  logic          note_valid;
  logic [2:0]    note_idx;
  logic          any_key;

  int total = 0;
  int bad   = 0;
  logic [BB-1:0] exp_press_q[$];

  key_conditioner #(.TICK_DIV(TICK_DIV), .DB_MS(DB_MS), .NK(NK), .LK(LK)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .note_key_raw   (note_key_raw),
    .length_key_raw (length_key_raw),
    .btn_raw        (btn_raw),
    .note_key       (note_key),
    .length_key     (length_key),
    .btn_level      (btn_level),
    .btn_press      (btn_press),
    .note_valid     (note_valid),
    .note_idx       (note_idx),
    .any_key        (any_key)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Cycles until btn_level[b] reaches val (bounded at 30).
  task automatic wait_btn(input int b, input logic val, output int n);
    n = 0;
    while (btn_level[b] !== val && n < 30) begin
      step(1);
      n++;
    end
  endtask

  task automatic wait_note(input logic [NK-1:0] val, output int n);
    n = 0;
    while (note_key !== val && n < 30) begin
      step(1);
      n++;
    end
  endtask

  // Monitor: every cycle with a press pulse must match the next expected event.
  always @(negedge clk) begin
    if (rst_n && btn_press != '0) begin
      total++;
      if (exp_press_q.size() == 0) begin
        bad++;
        $display("FAIL press_unexpected: got %b expected none", btn_press);
      end else begin
        logic [BB-1:0] e;
        e = exp_press_q.pop_front();
        if (btn_press !== e) begin
          bad++;
          $display("FAIL press_value: got %b expected %b", btn_press, e);
        end
      end
    end
  end

  initial begin
    int n;
    logic hi_seen;

    // 1. Reset with everything raw high.
    note_key_raw = '1; length_key_raw = '1; btn_raw = '1;
    step(4);
    check("reset_outputs", {note_key, length_key, btn_level, btn_press, note_valid, note_idx, any_key}, 32'd0);
    rst_n = 1'b1;
    exp_press_q.push_back(4'b1111);
    check("first_cycle_outputs", {note_key, length_key, btn_level, btn_press, note_valid, note_idx, any_key}, 32'd0);
    n = 0;
    while (!(&btn_level && &note_key && &length_key) && n < 30) begin
      step(1);
      n++;
    end
    check_rng("reset_levels_rise", n, 1, 15);
    step(2);
    check("all_set_not_valid", {note_valid, note_idx, any_key}, {1'b0, 3'd0, 1'b1});
    note_key_raw = '0; length_key_raw = '0; btn_raw = '0;
    step(20);
    check("all_cleared", {note_key, length_key, btn_level, any_key}, 32'd0);

    // 2. Clean press and release on submit.
    exp_press_q.push_back(4'b0001);
    btn_raw[0] = 1'b1;
    wait_btn(0, 1'b1, n);
    check_rng("press_latency", n, 11, 15);
    step(40 - n);
    btn_raw[0] = 1'b0;
    wait_btn(0, 1'b0, n);
    check_rng("release_latency", n, 11, 15);
    step(10);

    // 3. Bounce on cancel toggling every 3 cycles.
    hi_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      btn_raw[1] = ~btn_raw[1];
      for (int j = 0; j < 3; j++) begin
        step(1);
        if (btn_level[1]) hi_seen = 1'b1;
      end
    end
    btn_raw[1] = 1'b0;
    for (int j = 0; j < 20; j++) begin
      step(1);
      if (btn_level[1]) hi_seen = 1'b1;
    end
    check("bounce_level", {31'd0, hi_seen}, 32'd0);

    // 4. Note decode; decode lags note_key by one cycle.
    note_key_raw = 7'b0000100;
    wait_note(7'b0000100, n);
    check_rng("note_settle", n, 11, 15);
    check("note_lag", {note_valid, note_idx}, {1'b0, 3'd0});
    step(1);
    check("note_single", {note_valid, note_idx, any_key}, {1'b1, 3'd2, 1'b1});
    note_key_raw = 7'b0000110;
    wait_note(7'b0000110, n);
    step(1);
    check("note_multi", {note_valid, note_idx}, {1'b0, 3'd0});
    note_key_raw = 7'b1000000;
    wait_note(7'b1000000, n);
    step(1);
    check("note_msb", {note_valid, note_idx}, {1'b1, 3'd6});
    note_key_raw = 7'b0000000;
    wait_note(7'b0000000, n);
    step(1);
    check("note_none", {note_valid, note_idx, any_key}, {1'b0, 3'd0, 1'b0});
    length_key_raw = 7'b0101010;
    step(20);
    check("length_level", {25'd0, length_key}, {25'd0, 7'b0101010});
    check("length_any", {note_valid, any_key}, {1'b0, 1'b1});
    length_key_raw = '0;
    step(20);
    check("length_clear_any", {31'd0, any_key}, 32'd0);

    // 5. Two buttons rising together.
    exp_press_q.push_back(4'b0011);
    btn_raw[1:0] = 2'b11;
    step(20);
    check("simul_levels", {28'd0, btn_level}, {28'd0, 4'b0011});
    btn_raw = '0;
    step(20);

    // 6. Reset mid-count discards progress.
    btn_raw[0] = 1'b1;
    step(8);
    check("midcount_level", {31'd0, btn_level[0]}, 32'd0);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    exp_press_q.push_back(4'b0001);
    wait_btn(0, 1'b1, n);
    check_rng("requalify_latency", n, 11, 15);
    step(10);
    btn_raw = '0;
    step(20);

    check("press_queue_empty", exp_press_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
